// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard/branch controller
//
// Purpose: predictor state encoding, default predictor reset state and the
//          saturating next-state helper used by branch_predictor_2bit.
// Ports:   none (package)

package pipeline_ctrl_pkg;

   // 2-bit saturating counter states; the MSB is the taken/not-taken prediction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pred_state_t;

   // Weakly taken after reset.
   localparam logic [1:0] PRED_INIT_DEFAULT = 2'b10;

   // Move one step toward the resolved outcome, saturating at the end states.
   function automatic pred_state_t pred_step(input pred_state_t cur, input logic taken);
      pred_state_t nxt;
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_predictor.sv
// rtl/pipeline_ctrl_predictor.sv - 2-bit saturating branch predictor FSM
//
// Purpose: holds the single global 2-bit predictor. The state moves one step
//          toward the resolved outcome on every edge with update=1 and holds
//          otherwise. Synchronous active-high reset to PRED_INIT.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   update   in   a branch resolved this cycle
//   taken    in   resolved outcome of that branch
//   state    out  current predictor state
//   predict  out  current prediction (state MSB)

module branch_predictor_2bit
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [1:0] PRED_INIT = PRED_INIT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       update,
   input  logic       taken,
   output logic [1:0] state,
   output logic       predict
);

   pred_state_t state_q;
   pred_state_t state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= pred_state_t'(PRED_INIT);
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (update) begin
         state_d = pred_step(state_q, taken);
      end
   end

   assign state   = state_q;
   assign predict = state_q[1];

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - load-use hazard and branch-recovery controller for the 5-stage pipeline
//
// Purpose: detects load-use hazards and EX-stage mispredictions, drives the
//          stall/flush controls and PC source select, hosts the branch
//          predictor and keeps branch/mispredict/stall performance counters.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i         source registers of the instruction in ID
//   id_branch_i                instruction in ID is a branch
//   ex_memread_i, ex_rd_i      instruction in EX is a load, and its rd
//   ex_branch_i                branch in EX resolved this cycle
//   ex_taken_i, ex_predict_i   actual outcome and carried prediction of that branch
//   predict_o                  prediction for the branch in ID
//   stall_o                    hold PC and IF/ID
//   ifid_flush_o               squash IF/ID
//   idex_flush_o               insert bubble into ID/EX
//   pc_sel_o                   1 = load PC from the EX not-chosen PC
//   pred_state_o               current predictor state
//   branch_cnt_o, mispredict_cnt_o, stall_cnt_o   performance counters

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int         CNT_W     = 32,
   parameter logic [1:0] PRED_INIT = PRED_INIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_branch_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_branch_i,
   input  logic             ex_taken_i,
   input  logic             ex_predict_i,
   output logic             predict_o,
   output logic             stall_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             pc_sel_o,
   output logic [1:0]       pred_state_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispredict_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic hazard;
   logic mispredict;
   logic predict;

   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispredict_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q;

   branch_predictor_2bit #(
      .PRED_INIT (PRED_INIT)
   ) u_predictor (
      .clk     (clk),
      .reset   (reset),
      .update  (ex_branch_i),
      .taken   (ex_taken_i),
      .state   (pred_state_o),
      .predict (predict)
   );

   assign predict_o = predict;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign hazard = ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

   assign mispredict = ex_branch_i && (ex_taken_i != ex_predict_i);

   // A mispredict squashes the dependent ID instruction anyway, so it takes
   // priority over the stall. The predicted-taken redirect for an ID branch is
   // only taken when that branch is actually leaving ID (no stall).
   always_comb begin
      stall_o      = 1'b0;
      idex_flush_o = 1'b0;
      pc_sel_o     = 1'b0;
      ifid_flush_o = 1'b0;
      if (!reset) begin
         stall_o      = hazard && !mispredict;
         idex_flush_o = hazard || mispredict;
         pc_sel_o     = mispredict;
         ifid_flush_o = mispredict || (id_branch_i && predict && !hazard);
      end
   end

   // Reset takes precedence over every increment in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
         stall_cnt_q      <= '0;
      end else begin
         if (ex_branch_i) begin
            branch_cnt_q <= branch_cnt_q + CNT_ONE;
         end
         if (mispredict) begin
            mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
         end
         if (stall_o) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
      end
   end

   assign branch_cnt_o     = branch_cnt_q;
   assign mispredict_cnt_o = mispredict_cnt_q;
   assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl (32-bit and 4-bit counter builds)

module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic       id_branch_i, ex_memread_i, ex_branch_i, ex_taken_i, ex_predict_i;

   logic        predict_o, stall_o, ifid_flush_o, idex_flush_o, pc_sel_o;
   logic [1:0]  pred_state_o;
   logic [31:0] branch_cnt_o, mispredict_cnt_o, stall_cnt_o;

   logic        predict4, stall4, ifid_flush4, idex_flush4, pc_sel4;
   logic [1:0]  pred_state4;
   logic [3:0]  branch_cnt4, mispredict_cnt4, stall_cnt4;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int          m_pred;
   int unsigned m_branch, m_mispred, m_stall;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_branch_i(id_branch_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_branch_i(ex_branch_i),
      .ex_taken_i(ex_taken_i), .ex_predict_i(ex_predict_i),
      .predict_o(predict_o), .stall_o(stall_o), .ifid_flush_o(ifid_flush_o),
      .idex_flush_o(idex_flush_o), .pc_sel_o(pc_sel_o), .pred_state_o(pred_state_o),
      .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o),
      .stall_cnt_o(stall_cnt_o)
   );

   pipeline_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_branch_i(id_branch_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_branch_i(ex_branch_i),
      .ex_taken_i(ex_taken_i), .ex_predict_i(ex_predict_i),
      .predict_o(predict4), .stall_o(stall4), .ifid_flush_o(ifid_flush4),
      .idex_flush_o(idex_flush4), .pc_sel_o(pc_sel4), .pred_state_o(pred_state4),
      .branch_cnt_o(branch_cnt4), .mispredict_cnt_o(mispredict_cnt4),
      .stall_cnt_o(stall_cnt4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic idb, input logic mr, input logic [4:0] rd,
                        input logic exb, input logic tk, input logic pr);
      reset = rst; id_rs1_i = rs1; id_rs2_i = rs2; id_branch_i = idb;
      ex_memread_i = mr; ex_rd_i = rd; ex_branch_i = exb; ex_taken_i = tk; ex_predict_i = pr;
   endtask

   // One clock: check same-cycle controls against the rules, clock it, update
   // the model and check the registered state and counters.
   task automatic step();
      logic hz, mp, pred, e_stall, e_idex, e_pcsel, e_ifid;
      #1;
      pred = (m_pred >= 2);
      hz = ex_memread_i && (ex_rd_i != 0) && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
      mp = ex_branch_i && (ex_taken_i != ex_predict_i);
      e_stall = !reset && hz && !mp;
      e_idex  = !reset && (hz || mp);
      e_pcsel = !reset && mp;
      e_ifid  = !reset && (mp || (id_branch_i && pred && !hz));
      check("predict", {31'b0, predict_o}, {31'b0, pred});
      check("stall", {31'b0, stall_o}, {31'b0, e_stall});
      check("idex_flush", {31'b0, idex_flush_o}, {31'b0, e_idex});
      check("pc_sel", {31'b0, pc_sel_o}, {31'b0, e_pcsel});
      check("ifid_flush", {31'b0, ifid_flush_o}, {31'b0, e_ifid});
      check("stall_w4", {31'b0, stall4}, {31'b0, e_stall});
      @(posedge clk);
      if (reset) begin
         m_pred = 2; m_branch = 0; m_mispred = 0; m_stall = 0;
      end else begin
         if (ex_branch_i) begin
            m_branch++;
            if (ex_taken_i) m_pred = (m_pred == 3) ? 3 : m_pred + 1;
            else            m_pred = (m_pred == 0) ? 0 : m_pred - 1;
         end
         if (mp) m_mispred++;
         if (e_stall) m_stall++;
      end
      #1;
      check("pred_state", {30'b0, pred_state_o}, m_pred);
      check("branch_cnt", branch_cnt_o, m_branch);
      check("mispredict_cnt", mispredict_cnt_o, m_mispred);
      check("stall_cnt", stall_cnt_o, m_stall);
      check("pred_state_w4", {30'b0, pred_state4}, m_pred);
      check("branch_cnt_w4", {28'b0, branch_cnt4}, m_branch % 16);
      check("mispredict_cnt_w4", {28'b0, mispredict_cnt4}, m_mispred % 16);
      check("stall_cnt_w4", {28'b0, stall_cnt4}, m_stall % 16);
   endtask

   initial begin
      m_pred = 2; m_branch = 0; m_mispred = 0; m_stall = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      step();
      step();
      // Idle after reset: weakly taken, counters zero, controls zero
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("reset_pred_state", {30'b0, pred_state_o}, 32'h2);
      check("reset_branch_cnt", branch_cnt_o, 32'h0);
      // Load-use hazard on rs2, then same with rd = x0
      drive(0, 1, 5, 0, 1, 5, 0, 0, 0);
      step();
      check("hazard_stall_cnt", stall_cnt_o, 32'h1);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      step();
      // Three taken then four not-taken resolved branches, all predicted right
      repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 1, 1); step(); end
      check("sat_taken", {30'b0, pred_state_o}, 32'h3);
      repeat (4) begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step(); end
      check("sat_not_taken", {30'b0, pred_state_o}, 32'h0);
      check("branch_cnt_7", branch_cnt_o, 32'h7);
      // Mispredict together with a hazard
      drive(0, 7, 0, 1, 1, 7, 1, 0, 1);
      step();
      check("mp_hazard_stall_cnt", stall_cnt_o, 32'h1);
      check("mp_hazard_mispredict_cnt", mispredict_cnt_o, 32'h1);
      // Raise predictor to taken, then ID branch with and without a hazard
      repeat (2) begin drive(0, 0, 0, 0, 0, 0, 1, 1, 1); step(); end
      drive(0, 3, 4, 1, 0, 0, 0, 0, 0);
      step();
      drive(0, 3, 4, 1, 1, 4, 0, 0, 0);
      step();
      // Sixteen stall cycles wrap the 4-bit stall counter back to its start
      repeat (16) begin drive(0, 9, 2, 0, 1, 9, 0, 0, 0); step(); end
      check("stall_wrap_w4", {28'b0, stall_cnt4}, 32'h2);
      // Reset during a mispredict-plus-hazard cycle
      drive(1, 6, 0, 1, 1, 6, 1, 1, 0);
      step();
      check("rst_mp_branch_cnt", branch_cnt_o, 32'h0);
      check("rst_mp_stall_cnt_w4", {28'b0, stall_cnt4}, 32'h0);
      // Randomized traffic with narrow register ranges to provoke matches
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and branch-recovery controller for the 5-stage RISC-V pipeline. It detects load-use hazards and branch mispredictions and drives the stall/flush controls of the IF/ID and ID/EX pipeline registers and the PC source select. It holds the 2-bit saturating branch predictor whose prediction is carried down the pipe. It also keeps branch, mispredict and stall performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- PRED_INIT, 2'b10, predictor state after reset (weakly taken)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs1_i  in  5  rs1 field of instruction in ID
- id_rs2_i  in  5  rs2 field of instruction in ID
- id_branch_i  in  1  instruction in ID is a branch
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  rd field of instruction in EX
- ex_branch_i  in  1  instruction in EX is a branch, resolved this cycle
- ex_taken_i  in  1  actual branch outcome in EX
- ex_predict_i  in  1  prediction carried with the EX branch
- predict_o  out  1  prediction for the branch in ID, goes to ID/EX branch_predict
- stall_o  out  1  hold PC and IF/ID
- ifid_flush_o  out  1  squash IF/ID
- idex_flush_o  out  1  to ID/EX flush input; inserts a bubble
- pc_sel_o  out  1  1 = load PC from the EX not-chosen PC
- pred_state_o  out  2  current predictor state
- branch_cnt_o  out  CNT_W  resolved branches
- mispredict_cnt_o  out  CNT_W  mispredictions
- stall_cnt_o  out  CNT_W  load-use stall cycles

## Operation
- Hazard: hazard = ex_memread_i & (ex_rd_i != 0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i).
- Mispredict: mispredict = ex_branch_i & (ex_taken_i != ex_predict_i).
- Priority: mispredict over hazard.
  - stall_o = hazard & ~mispredict.
  - idex_flush_o = hazard | mispredict.
  - pc_sel_o = mispredict.
- Predicted-taken redirect: ifid_flush_o = mispredict | (id_branch_i & predict_o & ~hazard).
- Predictor FSM, states SNT=00, WNT=01, WT=10, ST=11; predict_o = state[1].
  - On each edge with ex_branch_i=1: taken increments the state, saturating at ST; not taken decrements it, saturating at SNT.
  - Without a resolved branch the state holds.
- Counters update on the edge:
  - branch_cnt +1 when ex_branch_i.
  - mispredict_cnt +1 when mispredict.
  - stall_cnt +1 when stall_o.
  - All counters wrap modulo 2^CNT_W; no saturation.
- Register x0 never causes a hazard.

## Timing
- Control outputs (stall_o, ifid_flush_o, idex_flush_o, pc_sel_o) are combinational from inputs and state, valid in the same cycle; zero cycles latency.
- While reset=1, all control outputs are forced to 0.
- Predictor and counter updates become visible the cycle after the triggering edge.
- Reset values: state=PRED_INIT, so predict_o=PRED_INIT[1] and pred_state_o=PRED_INIT; all counters 0; control outputs 0.
- Reset is sampled on the edge. Reset asserted mid-stall or mid-mispredict discards that cycle's updates; reset wins over all increments.
- A load-use stall lasts exactly one cycle: the bubble leaves ex_memread_i=0 on the next cycle.
- Mispredict in the same cycle as a hazard:
  - Outputs are stall_o=0 and idex_flush_o=1, ifid_flush_o=1, pc_sel_o=1.
  - stall_cnt does not increment.
- Mispredict with id_branch_i=1: the ID branch is squashed, and its prediction is irrelevant.

## Structure
- Package pipeline_ctrl_pkg holds the pred_state_t encodings (SNT/WNT/WT/ST) and the default PRED_INIT constant.
- Sub-module branch_predictor_2bit implements the saturating FSM: clk, reset, update, taken in; state, predict out.
- Counters and hazard logic stay in the top module.

## Test plan
- Reset, then idle: predict_o=1, pred_state_o=10, all counters 0, all controls 0.
- ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 -> stall_o=1, idex_flush_o=1, stall_cnt=1 next cycle. Repeat with ex_rd_i=0 -> no stall.
- Three resolved taken branches from WT -> state 11 and stays 11. Four not-taken branches -> 10, 01, 00, 00. branch_cnt=7.
- ex_branch_i=1, ex_predict_i=1, ex_taken_i=0 together with a hazard -> pc_sel_o=1, both flushes 1, stall_o=0; mispredict_cnt +1, stall_cnt unchanged.
- id_branch_i=1 with predict_o=1 and no hazard -> ifid_flush_o=1, idex_flush_o=0. Same case with a hazard -> ifid_flush_o=0, stall_o=1.
- CNT_W=4 with 16 stall cycles -> stall_cnt wraps to 0. Reset asserted during a mispredict cycle -> controls 0 and counters 0 after the edge.
